riscv_tpr_update_ctrl: RTL and testbench

Sequences every update of the Tag Propagation Register (TPR) that drives the EX-stage mode decoder, so that a policy change never takes effect while an instruction decoded under the old policy is still in flight. It accepts a masked write request and stalls ID issue. It drains the downstream pipeline for a configurable number of idle cycles, then commits the merged value atomically and signals completion. It sits between the CSR write port and the TPR consumers in the ID/EX stages.

---
 rtl/riscv_tpr_update_ctrl.sv | 108 ++++++++++
 tb/tb_riscv_tpr_update_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_tpr_update_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : riscv_tpr_update_ctrl
// Brief    : Sequences masked TPR updates by stalling ID issue, waiting for
//            enough idle EX cycles, then committing the merged value.
// Revision : 1.0 - initial release
// ============================================================================
module riscv_tpr_update_ctrl #(
  parameter int unsigned PIPE_DEPTH = 2,
  parameter logic [31:0] TPR_RESET  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_req_i,
  input  logic [31:0] cfg_wdata_i,
  input  logic [31:0] cfg_mask_i,
  output logic        cfg_gnt_o,
  output logic        cfg_done_o,
  input  logic        abort_i,
  input  logic        ex_busy_i,
  output logic        id_stall_o,
  output logic [31:0] tpr_o
);

  localparam logic [3:0] c_cnt_load = 4'(PIPE_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic [31:0] r_pend_wdata;
  logic [31:0] r_pend_mask;
  logic [31:0] r_tpr;
  logic        w_grant;
  logic        w_commit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 4'd0;
      r_pend_wdata <= 32'd0;
      r_pend_mask  <= 32'd0;
      r_tpr        <= TPR_RESET;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_grant) begin
        r_pend_wdata <= cfg_wdata_i;
        r_pend_mask  <= cfg_mask_i;
      end
      // Only unmasked bits of the active policy survive the merge.
      if (w_commit) begin
        r_tpr <= (r_tpr & ~r_pend_mask) | (r_pend_wdata & r_pend_mask);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_grant     = 1'b0;
    w_commit    = 1'b0;
    id_stall_o  = 1'b0;
    cfg_done_o  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_grant = cfg_req_i;
        if (cfg_req_i) begin
          w_cnt_nxt   = c_cnt_load;
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        id_stall_o = 1'b1;
        // Exit at 1 so the counter never wraps below zero.
        if (abort_i) begin
          w_state_nxt = ST_IDLE;
        end else if (!ex_busy_i) begin
          if (r_cnt == 4'd1) begin
            w_state_nxt = ST_COMMIT;
          end else begin
            w_cnt_nxt = r_cnt - 4'd1;
          end
        end
      end
      ST_COMMIT: begin
        id_stall_o  = 1'b1;
        cfg_done_o  = 1'b1;
        w_commit    = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign cfg_gnt_o = w_grant;
  assign tpr_o     = r_tpr;

endmodule
`default_nettype wire

// File: tb/tb_riscv_tpr_update_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_tpr_update_ctrl
// Brief    : Two-instance bench (different depth/reset value) with a
//            behavioural update model, directed cases and random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_tpr_update_ctrl;

  localparam int unsigned DEP0   = 2;
  localparam int unsigned DEP1   = 3;
  localparam logic [31:0] RST0   = 32'h0000_0000;
  localparam logic [31:0] RST1   = 32'hA5A5_A5A5;
  localparam int          N_RAND = 3000;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        req   = 1'b0;
  logic        abort = 1'b0;
  logic        busy  = 1'b0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] mask  = 32'd0;

  logic        gnt   [2];
  logic        done  [2];
  logic        stall [2];
  logic [31:0] tpr   [2];

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  riscv_tpr_update_ctrl #(.PIPE_DEPTH(DEP0), .TPR_RESET(RST0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .cfg_req_i(req), .cfg_wdata_i(wdata),
    .cfg_mask_i(mask), .cfg_gnt_o(gnt[0]), .cfg_done_o(done[0]),
    .abort_i(abort), .ex_busy_i(busy), .id_stall_o(stall[0]), .tpr_o(tpr[0])
  );

  riscv_tpr_update_ctrl #(.PIPE_DEPTH(DEP1), .TPR_RESET(RST1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .cfg_req_i(req), .cfg_wdata_i(wdata),
    .cfg_mask_i(mask), .cfg_gnt_o(gnt[1]), .cfg_done_o(done[1]),
    .abort_i(abort), .ex_busy_i(busy), .id_stall_o(stall[1]), .tpr_o(tpr[1])
  );

  function automatic int depth_of(input int d);
    return (d == 0) ? int'(DEP0) : int'(DEP1);
  endfunction

  function automatic logic [31:0] reset_of(input int d);
    return (d == 0) ? RST0 : RST1;
  endfunction

  // Behavioural model: an accepted update waits for depth_of(d) idle EX
  // cycles, then spends one cycle being applied.
  bit          m_draining   [2];
  bit          m_committing [2];
  int          m_idle_seen  [2];
  logic [31:0] m_tpr        [2];
  logic [31:0] m_wd         [2];
  logic [31:0] m_mk         [2];

  always @(posedge clk or negedge rst_n) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        m_draining[d]   <= 1'b0;
        m_committing[d] <= 1'b0;
        m_idle_seen[d]  <= 0;
        m_tpr[d]        <= reset_of(d);
      end else if (m_committing[d]) begin
        m_tpr[d]        <= (m_tpr[d] & ~m_mk[d]) | (m_wd[d] & m_mk[d]);
        m_committing[d] <= 1'b0;
      end else if (m_draining[d]) begin
        if (abort) begin
          m_draining[d] <= 1'b0;
        end else if (!busy) begin
          m_idle_seen[d] <= m_idle_seen[d] + 1;
          if (m_idle_seen[d] + 1 == depth_of(d)) begin
            m_draining[d]   <= 1'b0;
            m_committing[d] <= 1'b1;
          end
        end
      end else if (req) begin
        m_draining[d]  <= 1'b1;
        m_idle_seen[d] <= 0;
        m_wd[d]        <= wdata;
        m_mk[d]        <= mask;
      end
    end
  end

  task automatic check(input string nm, input int d, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d actual=%h required=%h", nm, d, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int d = 0; d < 2; d++) begin
        check("gnt",   d, {31'd0, gnt[d]},
              {31'd0, req && !m_draining[d] && !m_committing[d]});
        check("stall", d, {31'd0, stall[d]},
              {31'd0, m_draining[d] || m_committing[d]});
        check("done",  d, {31'd0, done[d]}, {31'd0, m_committing[d]});
        check("tpr",   d, tpr[d], m_tpr[d]);
      end
    end
  end

  // One request at k=0 on dut0, with literal expectations for the outcome.
  task automatic directed(input string nm, input logic [31:0] wd,
                          input logic [31:0] mk, input int busy_from,
                          input int busy_n, input int abort_at,
                          input int exp_done, input int exp_last_stall,
                          input logic [31:0] exp_tpr);
    int done_at    = -1;
    int first_stall = -1;
    int last_stall = -1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      req   = (k == 0);
      wdata = wd;
      mask  = mk;
      busy  = (k >= busy_from) && (k < busy_from + busy_n);
      abort = (k == abort_at);
      @(negedge clk);
      if (k == 0) check({nm, "_gnt"}, 0, {31'd0, gnt[0]}, 32'd1);
      if (done[0]) done_at = k;
      if (stall[0]) begin
        if (first_stall < 0) first_stall = k;
        last_stall = k;
      end
    end
    check({nm, "_done_cycle"},  0, done_at, exp_done);
    check({nm, "_first_stall"}, 0, first_stall, 1);
    check({nm, "_last_stall"},  0, last_stall, exp_last_stall);
    check({nm, "_tpr"},         0, tpr[0], exp_tpr);
  endtask

  initial begin
    int gnt2_at;
    int done_a;
    int done_b;
    bit granted2;

    #2 rst_n = 1'b0;
    #1;
    check("rst_tpr",   0, tpr[0], 32'h0000_0000);
    check("rst_tpr",   1, tpr[1], 32'hA5A5_A5A5);
    check("rst_done",  0, {31'd0, done[0]}, 32'd0);
    check("rst_stall", 0, {31'd0, stall[0]}, 32'd0);
    check("rst_gnt",   0, {31'd0, gnt[0]}, 32'd0);
    #20 rst_n = 1'b1;
    cmp_en = 1'b1;

    directed("basic",   32'h0000_00F3, 32'hFFFF_FFFF, 0, 0, -1, 3, 3, 32'h0000_00F3);
    directed("full",    32'hFFFF_0000, 32'hFFFF_FFFF, 0, 0, -1, 3, 3, 32'hFFFF_0000);
    directed("merge",   32'h1234_5678, 32'h00FF_00FF, 0, 0, -1, 3, 3, 32'hFF34_0078);
    directed("busy",    32'h0000_0000, 32'h0000_000F, 1, 3, -1, 6, 6, 32'hFF34_0070);
    directed("mask0",   32'hDEAD_BEEF, 32'h0000_0000, 0, 0, -1, 3, 3, 32'hFF34_0070);
    directed("abort",   32'h0000_0000, 32'hFFFF_FFFF, 0, 0,  2, -1, 2, 32'hFF34_0070);
    directed("abortcm", 32'h0000_0001, 32'hFFFF_FFFF, 0, 0,  3, 3, 3, 32'h0000_0001);

    // Back-to-back: a second requester holds from k=1 until granted.
    gnt2_at  = -1;
    done_a   = -1;
    done_b   = -1;
    granted2 = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      req   = (k == 0) || !granted2;
      wdata = (k == 0) ? 32'h0000_FF00 : 32'h0000_0A0A;
      mask  = (k == 0) ? 32'h0000_FF00 : 32'h0000_0F0F;
      busy  = 1'b0;
      abort = 1'b0;
      @(negedge clk);
      if (k > 0 && gnt[0] && !granted2) begin
        gnt2_at  = k;
        granted2 = 1'b1;
      end
      if (done[0]) begin
        if (done_a < 0) done_a = k;
        else done_b = k;
      end
    end
    req = 1'b0;
    check("b2b_gnt2",  0, gnt2_at, 4);
    check("b2b_done1", 0, done_a, 3);
    check("b2b_done2", 0, done_b, 7);
    check("b2b_tpr",   0, tpr[0], 32'h0000_FA0A);

    // Asynchronous reset in the middle of DRAIN.
    @(posedge clk); #1;
    req = 1'b1; wdata = 32'hFFFF_FFFF; mask = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    req = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_tpr",   0, tpr[0], 32'h0000_0000);
    check("arst_tpr",   1, tpr[1], 32'hA5A5_A5A5);
    check("arst_stall", 0, {31'd0, stall[0]}, 32'd0);
    check("arst_done",  0, {31'd0, done[0]}, 32'd0);
    @(posedge clk); #3 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1 check("arst_after", 0, tpr[0], 32'h0000_0000);

    for (int i = 0; i < N_RAND; i++) begin
      @(posedge clk); #1;
      req   = ($urandom_range(0, 2) != 0);
      busy  = ($urandom_range(0, 9) < 4);
      abort = ($urandom_range(0, 9) == 0);
      wdata = $urandom;
      case ($urandom_range(0, 3))
        0:       mask = 32'h0000_0000;
        1:       mask = 32'hFFFF_FFFF;
        default: mask = $urandom;
      endcase
      if ($urandom_range(0, 599) == 0) begin
        #2 rst_n = 1'b0;
        @(posedge clk); #3 rst_n = 1'b1;
      end
    end

    @(posedge clk); #1;
    req = 1'b0; abort = 1'b0; busy = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
